// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller. Drives npc_out every cycle so that holds,
// increments, redirects and halts all reach a PC register that loads
// unconditionally. Keeps a shadow copy of the PC and qualifies fetch.
module pc_sequencer #(
  parameter int unsigned          PC_W         = 10,
  parameter logic [PC_W-1:0]      RESET_VECTOR = '0,
  parameter int unsigned          PC_STEP      = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            halt_req,
  input  logic            restart,
  output logic [PC_W-1:0] npc_out,
  output logic [PC_W-1:0] pc_shadow,
  output logic            fetch_valid,
  output logic            flush,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_RUN   = 3'd1,
    S_STALL = 3'd2,
    S_FLUSH = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_npc;
  logic            w_fetch_valid;
  logic            w_flush;
  logic            w_halted;

  // Sequential increment wraps naturally at the PC width.
  assign w_pc_inc = r_pc + PC_W'(PC_STEP);

  // State and shadow PC; the shadow follows npc so it mirrors the PC register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_INIT;
      r_pc    <= RESET_VECTOR;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_npc;
    end
  end

  // Next-state, next-PC and fetch qualifiers; priority halt > jump > branch > stall.
  always_comb begin
    w_state_next  = r_state;
    w_npc         = r_pc;
    w_fetch_valid = 1'b0;
    w_flush       = 1'b0;
    w_halted      = 1'b0;
    case (r_state)
      S_INIT: begin
        w_npc        = RESET_VECTOR;
        w_state_next = S_RUN;
      end
      S_RUN, S_STALL: begin
        w_fetch_valid = 1'b1;
        if (halt_req) begin
          w_npc        = r_pc;
          w_state_next = S_HALT;
        end else if (jump) begin
          w_npc        = jump_target;
          w_state_next = S_FLUSH;
        end else if (branch_taken) begin
          w_npc        = branch_target;
          w_state_next = S_FLUSH;
        end else if (stall) begin
          w_npc        = r_pc;
          w_state_next = S_STALL;
        end else begin
          w_npc        = w_pc_inc;
          w_state_next = S_RUN;
        end
      end
      S_FLUSH: begin
        // Shadow already holds the target; step past it, giving one bubble.
        w_flush      = 1'b1;
        w_npc        = w_pc_inc;
        w_state_next = S_RUN;
      end
      S_HALT: begin
        w_halted = 1'b1;
        if (restart) begin
          w_npc        = RESET_VECTOR;
          w_state_next = S_INIT;
        end
      end
      default: begin
        w_npc        = RESET_VECTOR;
        w_state_next = S_INIT;
      end
    endcase
    if (reset) begin
      w_npc        = RESET_VECTOR;
      w_state_next = S_INIT;
    end
  end

  assign npc_out     = w_npc;
  assign pc_shadow   = r_pc;
  assign fetch_valid = w_fetch_valid;
  assign flush       = w_flush;
  assign halted      = w_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a table of per-cycle stimulus with the expected
// post-edge outputs, fed through a scoreboard queue.
module tb_pc_sequencer;

  localparam int unsigned PC_W = 10;

  logic            clock;
  logic            reset;
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            jump;
  logic [PC_W-1:0] jump_target;
  logic            halt_req;
  logic            restart;
  logic [PC_W-1:0] npc_out;
  logic [PC_W-1:0] pc_shadow;
  logic            fetch_valid;
  logic            flush;
  logic            halted;

  pc_sequencer #(
    .PC_W         (PC_W),
    .RESET_VECTOR (10'h000),
    .PC_STEP      (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt_req      (halt_req),
    .restart       (restart),
    .npc_out       (npc_out),
    .pc_shadow     (pc_shadow),
    .fetch_valid   (fetch_valid),
    .flush         (flush),
    .halted        (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic            rst;
    logic            stl;
    logic            br;
    logic [PC_W-1:0] bt;
    logic            jmp;
    logic [PC_W-1:0] jt;
    logic            hlt;
    logic            rs;
    logic [PC_W-1:0] pc;
    logic            fv;
    logic            fl;
    logic            hl;
  } vec_t;

  typedef struct {
    int              idx;
    logic [PC_W-1:0] pc;
    logic            fv;
    logic            fl;
    logic            hl;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  function automatic void add(logic rst, logic stl, logic br, logic [PC_W-1:0] bt,
                              logic jmp, logic [PC_W-1:0] jt, logic hlt, logic rs,
                              logic [PC_W-1:0] pc, logic fv, logic fl, logic hl);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt;
    v.hlt = hlt; v.rs = rs; v.pc = pc; v.fv = fv; v.fl = fl; v.hl = hl;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int idx, logic [PC_W-1:0] act, logic [PC_W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s vec%0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
  endtask

  // Checker: pops one expectation after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_shadow",   e.idx, pc_shadow, e.pc);
        chk("fetch_valid", e.idx, {9'd0, fetch_valid}, {9'd0, e.fv});
        chk("flush",       e.idx, {9'd0, flush},       {9'd0, e.fl});
        chk("halted",      e.idx, {9'd0, halted},      {9'd0, e.hl});
      end
    end
  end

  initial begin
    exp_t e;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; halt_req = 1'b0; restart = 1'b0;

    //   rst stl br bt       jmp jt       hlt rs  pc       fv fl hl
    // Reset then free run
    add(1, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h000, 0, 0, 0);
    add(1, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h000, 0, 0, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h000, 1, 0, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h004, 1, 0, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h008, 1, 0, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h00C, 1, 0, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h010, 1, 0, 0);
    // Stall three cycles at 0x010
    add(0, 1, 0, 10'h000, 0, 10'h000, 0, 0, 10'h010, 1, 0, 0);
    add(0, 1, 0, 10'h000, 0, 10'h000, 0, 0, 10'h010, 1, 0, 0);
    add(0, 1, 0, 10'h000, 0, 10'h000, 0, 0, 10'h010, 1, 0, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h014, 1, 0, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h018, 1, 0, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h01C, 1, 0, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h020, 1, 0, 0);
    // Branch + stall at 0x020, then branch + stall + jump
    add(0, 1, 1, 10'h100, 0, 10'h000, 0, 0, 10'h100, 0, 1, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h104, 1, 0, 0);
    add(0, 1, 1, 10'h100, 1, 10'h200, 0, 0, 10'h200, 0, 1, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h204, 1, 0, 0);
    // Requests during FLUSH are ignored
    add(0, 0, 0, 10'h000, 1, 10'h2F0, 0, 0, 10'h2F0, 0, 1, 0);
    add(0, 1, 1, 10'h080, 1, 10'h050, 1, 0, 10'h2F4, 1, 0, 0);
    // Wrap-around from 0x3F8
    add(0, 0, 0, 10'h000, 1, 10'h3F8, 0, 0, 10'h3F8, 0, 1, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h3FC, 1, 0, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h000, 1, 0, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h004, 1, 0, 0);
    // Halt at 0x040 (with simultaneous jump), inputs toggle, then restart
    add(0, 0, 0, 10'h000, 1, 10'h03C, 0, 0, 10'h03C, 0, 1, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h040, 1, 0, 0);
    add(0, 0, 0, 10'h000, 1, 10'h123, 1, 0, 10'h040, 0, 0, 1);
    add(0, 1, 0, 10'h000, 0, 10'h000, 0, 0, 10'h040, 0, 0, 1);
    add(0, 0, 1, 10'h1A0, 1, 10'h2A0, 0, 0, 10'h040, 0, 0, 1);
    add(0, 1, 0, 10'h000, 1, 10'h150, 1, 0, 10'h040, 0, 0, 1);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h040, 0, 0, 1);
    add(0, 0, 0, 10'h000, 1, 10'h150, 0, 1, 10'h000, 0, 0, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h000, 1, 0, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h004, 1, 0, 0);
    // Reset during the FLUSH after a jump to 0x300
    add(0, 0, 0, 10'h000, 1, 10'h300, 0, 0, 10'h300, 0, 1, 0);
    add(1, 0, 0, 10'h000, 1, 10'h111, 0, 0, 10'h000, 0, 0, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h000, 1, 0, 0);
    // Restart in RUN does nothing; halt beats restart; restart from HALT
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 1, 10'h004, 1, 0, 0);
    add(0, 0, 0, 10'h000, 0, 10'h000, 1, 1, 10'h004, 0, 0, 1);
    add(0, 0, 0, 10'h000, 0, 10'h000, 0, 1, 10'h000, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset         = vecs[i].rst;
      stall         = vecs[i].stl;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].bt;
      jump          = vecs[i].jmp;
      jump_target   = vecs[i].jt;
      halt_req      = vecs[i].hlt;
      restart       = vecs[i].rs;
      #1;
      // npc_out is what the PC (and shadow) take at the coming edge.
      chk("npc_out", i, npc_out, vecs[i].pc);
      e.idx = i; e.pc = vecs[i].pc; e.fv = vecs[i].fv; e.fl = vecs[i].fl; e.hl = vecs[i].hl;
      sb.push_back(e);
    end

    @(posedge clock);
    #3;
    chk("sb_drain", 0, PC_W'(sb.size()), '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the 10-bit program counter register.
- The PC register loads its input unconditionally on every clock edge. This block therefore drives NPC every cycle so that holds, increments, redirects and halts all reach the PC.
- It keeps a shadow copy of the PC and arbitrates jump, branch, stall and halt requests from decode/execute.
- It outputs fetch-valid and flush qualifiers for the fetch stage.

Parameters:
- PC_W, 10, PC/NPC width in bits.
- RESET_VECTOR, 10'h000, PC value loaded by reset and by restart.
- PC_STEP, 4, sequential increment (byte-addressed, word-aligned).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the PC (hazard); ignored while redirect/halt is active.
- branch_taken  in  1  conditional branch resolved taken.
- branch_target  in  PC_W  branch destination.
- jump  in  1  unconditional jump.
- jump_target  in  PC_W  jump destination.
- halt_req  in  1  halt instruction decoded.
- restart  in  1  leave HALT, resume at RESET_VECTOR.
- npc_out  out  PC_W  value the PC register loads at the next edge (combinational from state and inputs).
- pc_shadow  out  PC_W  registered copy of the current PC register contents.
- fetch_valid  out  1  current PC addresses a valid fetch.
- flush  out  1  kill the instruction currently in fetch/decode (1 cycle).
- halted  out  1  sequencer is in HALT.

Behaviour:
- **State register:**
  - States are INIT, RUN, STALL, FLUSH, HALT.
  - Reset values: state=INIT, pc_shadow=RESET_VECTOR, fetch_valid=0, flush=0, halted=0.
  - While reset is high, npc_out=RESET_VECTOR.
- **Shadow tracking:** at every edge, pc_shadow <= npc_out. This keeps pc_shadow equal to the PC register.
- **Arithmetic:** increment is pc_shadow+PC_STEP, modulo 2^PC_W. 10'h3FC+4 wraps to 10'h000 with no flag. Targets are used as given; bits [1:0] are not checked.
- **Priority (highest first):** reset > halt_req > jump > branch_taken > stall > increment.
- **INIT:**
  - npc_out=RESET_VECTOR, fetch_valid=0.
  - Goes to RUN after one cycle.
  - All request inputs are ignored.
- **RUN:**
  - fetch_valid=1.
  - halt_req: npc_out=pc_shadow, go to HALT.
  - jump: npc_out=jump_target, go to FLUSH.
  - branch_taken (no jump): npc_out=branch_target, go to FLUSH.
  - stall: npc_out=pc_shadow, go to STALL.
  - Otherwise: npc_out=pc_shadow+PC_STEP, stay in RUN.
- **STALL:**
  - fetch_valid=1; the instruction is held, not killed.
  - Same decode as RUN, so a redirect or halt breaks the stall immediately.
  - stall low returns to RUN with npc_out=pc_shadow+PC_STEP.
- **FLUSH:**
  - flush=1, fetch_valid=0 for exactly 1 cycle.
  - npc_out=pc_shadow+PC_STEP, with pc_shadow holding the target. This gives 1 bubble per redirect.
  - Requests arriving in this cycle are ignored; upstream must hold them.
  - Goes to RUN.
- **HALT:**
  - halted=1, fetch_valid=0, npc_out=pc_shadow (PC frozen).
  - restart: npc_out=RESET_VECTOR, go to INIT.
  - All other inputs are ignored.
- **Simultaneous events:**
  - jump+branch_taken: jump wins.
  - halt_req+jump: halt wins and the PC freezes at the current value.
  - stall+branch_taken: branch wins, no stall cycle.
- **Reset mid-operation:** from any state, the next edge yields state INIT, pc_shadow=RESET_VECTOR, flush=0, halted=0.
- **Latency:**
  - Redirect request to target in PC: 1 edge.
  - Target to first valid fetch: 2 edges, target+4 with fetch_valid=1.

Test Plan:
1. **Reset then free run:** reset high 2 cycles, then low.
   - pc_shadow sequence 0x000 (INIT), 0x000 (RUN, fetch_valid=1), 0x004, 0x008, 0x00C.
2. **Stall:** assert stall for 3 cycles at pc=0x010.
   - pc_shadow holds 0x010 for 3 extra cycles with fetch_valid=1.
   - Then 0x014.
3. **Branch with simultaneous stall and jump:**
   - At pc=0x020, assert branch_taken with target 0x100, plus stall. Next pc=0x100, flush=1 for one cycle, then 0x104 with fetch_valid=1.
   - Repeat with jump=1, jump_target=0x200 in the same cycle. pc=0x200.
4. **Wrap-around:** run from pc=0x3F8.
   - Sequence 0x3FC, 0x000, 0x004; no stall or flush asserted.
5. **Halt/restart:** halt_req at pc=0x040.
   - pc frozen at 0x040, halted=1, fetch_valid=0 for 5 cycles while jump/stall toggle.
   - restart gives pc 0x000 in INIT, then RUN.
6. **Reset mid-FLUSH:** assert reset in the FLUSH cycle after a jump to 0x300.
   - Next cycle pc=0x000, state INIT, flush=0, halted=0.
